// File: rtl/myy_ctrl.sv
// Purpose : microprogram control unit that sequences the BO control lines y[10:1]
//           for ADD, SUB, NEG and MUL.
// Latency : ADD/SUB/NEG take 4 cycles from the accept edge to done. MUL takes 2*N+2 cycles.
// Backpr. : start is accepted only in IDLE. While busy, start is ignored and not queued.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - operation request; sampled in IDLE only
//   cop   - operation code captured with start (00 ADD, 01 SUB, 10 MUL, 11 NEG)
//   f     - BO flags: f[0] multiplier sign, f[1] analysed multiplier bit, f[2] rr is -0
//   y     - BO control lines; combinational from state, op and f
//   busy  - high from the cycle after an accepted start through the FLAG cycle inclusive
//   done  - one-cycle pulse in the FLAG cycle
module myy_ctrl #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cop,
  input  logic [2:0]  f,
  output logic [10:1] y,
  output logic        busy,
  output logic        done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    ROT  = 3'd3,
    ACC  = 3'd4,
    CORR = 3'd5,
    NORM = 3'd6,
    FLAG = 3'd7
  } state_t;

  state_t        state;
  logic [1:0]    op;
  logic [CW-1:0] cnt;

  // Sequencer. busy and done are registered together with the state, so they
  // change only on clock edges (or on reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= 2'b00;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op    <= cop;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (op == OP_MUL) begin
            // One ROT/ACC pair for each magnitude bit of the multiplier.
            cnt   <= CNT_INIT;
            state <= ROT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: state <= NORM;
        ROT:  state <= ACC;
        ACC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) state <= CORR;
          else                 state <= ROT;
        end
        CORR: state <= NORM;
        NORM: begin
          done  <= 1'b1;
          state <= FLAG;
        end
        FLAG: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control lines. BO flags are combinational from its registers, so f is used
  // in the same cycle that it is produced.
  always_comb begin
    y = '0;
    case (state)
      LOAD: begin
        y[1] = 1'b1;  // RA <- a
        y[2] = 1'b1;  // with y3: RB <- b
        y[3] = 1'b1;
        y[8] = 1'b1;  // rr <- 0
      end
      EXEC: begin
        y[6] = 1'b1;
        y[7] = 1'b1;  // rr <- sum
        case (op)
          OP_ADD: y[4] = 1'b1;
          OP_SUB: y[5] = 1'b1;
          OP_NEG: begin
            y[5] = 1'b1;
            y[9] = 1'b1;  // adder q = rr, which is still 0 after LOAD
          end
          default: ;
        endcase
      end
      ROT: y[7] = 1'b1;  // without y6: rotate rr left
      ACC: begin
        y[3] = 1'b1;  // without y2: shift RB left, keeping the sign
        // f[1] reflects RB before this cycle's shift.
        if (f[1]) begin
          y[4] = 1'b1;
          y[6] = 1'b1;
          y[7] = 1'b1;
          y[9] = 1'b1;
        end
      end
      CORR: begin
        // A negative one's-complement multiplier needs rr <- rr - A.
        if (f[0]) begin
          y[5] = 1'b1;
          y[6] = 1'b1;
          y[7] = 1'b1;
          y[9] = 1'b1;
        end
      end
      NORM: begin
        if (f[2]) y[8] = 1'b1;  // fold -0 into +0
      end
      FLAG: y[10] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_myy_ctrl.sv
module tb_myy_ctrl;

  localparam int N = 4;

  // Phase names used by the reference model.
  localparam int PH_LOAD = 1;
  localparam int PH_EXEC = 2;
  localparam int PH_ROT  = 3;
  localparam int PH_ACC  = 4;
  localparam int PH_CORR = 5;
  localparam int PH_NORM = 6;
  localparam int PH_FLAG = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cop;
  logic [2:0]  f;
  logic [10:1] y;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  myy_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cop   (cop),
    .f     (f),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [10:1] on(input int k);
    logic [10:1] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // Expected control word for a phase, taken directly from the line table.
  function automatic logic [10:1] expect_y(input int ph, input logic [1:0] o, input logic [2:0] fl);
    logic [10:1] r;
    r = '0;
    case (ph)
      PH_LOAD: r = on(1) | on(2) | on(3) | on(8);
      PH_EXEC: begin
        r = on(6) | on(7);
        if (o == 2'b00) r = r | on(4);
        if (o == 2'b01) r = r | on(5);
        if (o == 2'b11) r = r | on(5) | on(9);
      end
      PH_ROT:  r = on(7);
      PH_ACC:  r = on(3) | (fl[1] ? (on(4) | on(6) | on(7) | on(9)) : '0);
      PH_CORR: r = fl[0] ? (on(5) | on(6) | on(7) | on(9)) : '0;
      PH_NORM: r = fl[2] ? on(8) : '0;
      PH_FLAG: r = on(10);
      default: r = '0;
    endcase
    return r;
  endfunction

  // One idle cycle. The outputs must stay quiet whatever the flags are.
  task automatic idle_cycle(input logic st, input logic [1:0] c);
    @(posedge clk);
    #1;
    start = st;
    cop   = c;
    f     = 3'($urandom);
    @(negedge clk);
    check("idle_y", 32'(y), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  // Run one operation from IDLE through FLAG. The flags and start are
  // randomised in every busy cycle.
  task automatic run_op(input logic [1:0] o, input int gap);
    int ph_q[$];
    int done_cnt;
    int done_at;
    for (int g = 0; g < gap; g++) idle_cycle(1'b0, 2'($urandom));
    idle_cycle(1'b1, o);  // accepted on the next edge

    ph_q.push_back(PH_LOAD);
    if (o == 2'b10) begin
      for (int b = 0; b < N - 1; b++) begin
        ph_q.push_back(PH_ROT);
        ph_q.push_back(PH_ACC);
      end
      ph_q.push_back(PH_CORR);
    end else begin
      ph_q.push_back(PH_EXEC);
    end
    ph_q.push_back(PH_NORM);
    ph_q.push_back(PH_FLAG);

    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < ph_q.size(); i++) begin
      @(posedge clk);
      #1;
      f     = 3'($urandom);
      start = 1'($urandom_range(0, 1));  // must be ignored while busy
      cop   = 2'($urandom);
      @(negedge clk);
      check($sformatf("y_op%0d_ph%0d", o, ph_q[i]), 32'(y), 32'(expect_y(ph_q[i], o, f)));
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(ph_q[i] == PH_FLAG));
      if (done) begin
        done_cnt++;
        done_at = i + 1;
      end
    end
    check("done_pulses", 32'(done_cnt), 32'd1);
    check($sformatf("latency_op%0d", o), 32'(done_at), (o == 2'b10) ? 32'(2 * N + 2) : 32'd4);
  endtask

  // Start a MUL, then assert reset during the first ACC cycle.
  task automatic reset_mid_mul();
    idle_cycle(1'b1, 2'b10);
    repeat (3) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      f     = 3'($urandom);
    end
    @(negedge clk);
    check("pre_rst_acc_y", 32'(y), 32'(expect_y(PH_ACC, 2'b10, f)));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cop   = 2'b00;
    f     = 3'b111;
    #2;
    check("reset_y", 32'(y), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // One of each operation, back to back with the minimum gap.
    run_op(2'b00, 0);
    run_op(2'b01, 0);
    run_op(2'b10, 0);
    run_op(2'b11, 0);

    reset_mid_mul();
    run_op(2'b00, 1);
    run_op(2'b10, 0);

    for (int t = 0; t < 40; t++) run_op(2'($urandom), int'($urandom_range(0, 2)));

    idle_cycle(1'b0, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
